// File: rtl/per2axi_quiesce_ctrl.sv
// Quiesce controller for the per2axi bridge: blocks new peripheral requests,
// waits for AXI traffic to retire and a settle window to elapse, then acks.
module per2axi_quiesce_ctrl #(
    parameter int IDLE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       busy_i,
    input  logic       per_req_i,
    output logic       per_gnt_o,
    output logic       per_req_o,
    input  logic       per_gnt_i,
    input  logic       quiesce_req_i,
    output logic       quiesce_ack_o,
    output logic       timeout_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SETTLE = 2'd2, QUIESCED = 2'd3} state_e;

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    state_e          state_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            hold_q;
    logic            ack_q;
    logic            timeout_q;
    logic            to_hit;
    logic            block;

    // A request presented but not yet granted keeps passing until granted.
    assign block     = (state_q != RUN) && !hold_q;
    assign per_req_o = per_req_i && !block;
    assign per_gnt_o = per_gnt_i && per_req_o;

    // Saturating drain timer; a zero limit leaves it parked at 0.
    assign to_cnt_d  = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
    assign to_hit    = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_MAX - TW'(1));

    assign quiesce_ack_o = ack_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            idle_cnt_q <= '0;
            to_cnt_q   <= '0;
            hold_q     <= 1'b0;
            ack_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            hold_q    <= per_req_o && !per_gnt_i;
            timeout_q <= 1'b0;
            case (state_q)
                RUN: begin
                    to_cnt_q <= '0;
                    if (quiesce_req_i) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!quiesce_req_i) begin
                        state_q  <= RUN;
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q  <= to_cnt_d;
                        timeout_q <= to_hit;
                        if (!busy_i && !hold_q) begin
                            state_q    <= SETTLE;
                            idle_cnt_q <= '0;
                        end
                    end
                end
                SETTLE: begin
                    if (!quiesce_req_i) begin
                        state_q  <= RUN;
                        to_cnt_q <= '0;
                    end else if (!busy_i && idle_cnt_q == IDLE_LAST) begin
                        state_q  <= QUIESCED;
                        ack_q    <= 1'b1;
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q  <= to_cnt_d;
                        timeout_q <= to_hit;
                        if (busy_i) begin
                            state_q    <= DRAIN;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + IW'(1);
                        end
                    end
                end
                QUIESCED: begin
                    // Late busy activity is ignored; only dropping the request exits.
                    if (!quiesce_req_i) begin
                        state_q <= RUN;
                        ack_q   <= 1'b0;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_per2axi_quiesce_ctrl.sv
// Directed bench for per2axi_quiesce_ctrl with an attempt-level reference model.
module tb_per2axi_quiesce_ctrl;

    localparam int IDLE = 4;
    localparam int TO   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy = 1'b0, per_req_i = 1'b0, per_gnt_i = 1'b0, qreq = 1'b0;
    logic       per_gnt_o, per_req_o, ack, tmo;
    logic [1:0] state;

    int vectors = 0, miscompares = 0, tcnt = 0, t0;

    per2axi_quiesce_ctrl #(.IDLE_CYCLES(IDLE), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .busy_i(busy),
        .per_req_i(per_req_i), .per_gnt_o(per_gnt_o),
        .per_req_o(per_req_o), .per_gnt_i(per_gnt_i),
        .quiesce_req_i(qreq), .quiesce_ack_o(ack),
        .timeout_o(tmo), .state_o(state)
    );

    always #5 clk = ~clk;

    // Model: an attempt is active while quiesce is requested; m_run counts
    // consecutive settle cycles (0 = still draining), m_elapsed counts
    // drain+settle cycles of the attempt.
    bit m_active, m_quiesced, m_pending, m_to;
    int m_run, m_elapsed;

    function automatic logic [1:0] m_state();
        if (!m_active)   return 2'd0;
        if (m_quiesced)  return 2'd3;
        if (m_run > 0)   return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic m_req_o();
        return per_req_i && !(m_active && !m_pending);
    endfunction

    always @(posedge clk or posedge rst) begin
        bit exp_req;
        if (rst) begin
            m_active = 0; m_quiesced = 0; m_pending = 0; m_to = 0;
            m_run = 0; m_elapsed = 0;
        end else begin
            exp_req = m_req_o();
            m_to = 0;
            if (!m_active) begin
                if (qreq) begin m_active = 1; m_run = 0; m_elapsed = 0; end
            end else if (!qreq) begin
                m_active = 0; m_quiesced = 0;
            end else if (!m_quiesced) begin
                if (m_run == 0) begin
                    if (!busy && !m_pending) m_run = 1;
                end else if (busy)        m_run = 0;
                else if (m_run == IDLE)   m_quiesced = 1;
                else                      m_run++;
                if (!m_quiesced) begin
                    m_elapsed++;
                    if (m_elapsed == TO) m_to = 1;
                end
            end
            m_pending = exp_req && !per_gnt_i;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("state_o", state, m_state());
        check("ack", ack, m_quiesced);
        check("timeout", tmo, m_to);
        check("per_req_o", per_req_o, m_req_o());
        check("per_gnt_o", per_gnt_o, per_gnt_i && m_req_o());
        if (tmo === 1'b1) tcnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("reset state", state, 0);
        check("reset ack", ack, 0);
        check("reset timeout", tmo, 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Idle bridge: DRAIN at 1, SETTLE at 2, QUIESCED at 6.
        qreq = 1;
        step(1); check("s1 drain", state, 1);
        step(1); check("s1 settle", state, 2);
        step(3); check("s1 not yet", ack, 0);
        step(1); check("s1 quiesced", state, 3); check("s1 ack", ack, 1);
        qreq = 0;
        step(1); check("s1 release", state, 0); check("s1 ack drop", ack, 0);

        // Busy for 10 cycles with traffic offered.
        qreq = 1; busy = 1; per_gnt_i = 1;
        for (int i = 0; i < 10; i++) begin per_req_i = i[0]; step(1); end
        check("s2 still drain", state, 1);
        per_req_i = 0; busy = 0;
        step(1); check("s2 settle", state, 2);
        step(4); check("s2 quiesced", state, 3);
        qreq = 0; per_gnt_i = 0;
        step(1);

        // Stalled request across quiesce start.
        per_req_i = 1; qreq = 1;
        step(3); check("s3 held req", per_req_o, 1);
        per_gnt_i = 1; #1 check("s3 gnt", per_gnt_o, 1);
        step(1); check("s3 blocked", per_req_o, 0); check("s3 no gnt", per_gnt_o, 0);
        per_req_i = 0; per_gnt_i = 0;
        step(6); check("s3 quiesced", state, 3);
        qreq = 0; step(1);

        // Busy blip during settle cycle 3.
        qreq = 1;
        step(2); check("s4 settle", state, 2);
        step(2); busy = 1;
        step(1); check("s4 back to drain", state, 1);
        busy = 0;
        step(1); check("s4 settle again", state, 2);
        step(3); check("s4 no early ack", ack, 0);
        step(1); check("s4 ack", ack, 1);
        qreq = 0; step(1);

        // Stuck busy: one timeout pulse, then async reset.
        t0 = tcnt;
        qreq = 1; busy = 1;
        step(20);
        check("s5 one pulse", tcnt - t0, 1);
        check("s5 still drain", state, 1);
        rst = 1; #1;
        check("s5 rst state", state, 0);
        check("s5 rst tmo", tmo, 0);
        qreq = 0; busy = 0;
        step(1); rst = 0; step(1);

        // Abort during settle cycle 2.
        qreq = 1;
        step(3); check("s6 settle", state, 2);
        qreq = 0;
        step(1); check("s6 run", state, 0); check("s6 no ack", ack, 0);
        per_req_i = 1; per_gnt_i = 1; #1;
        check("s6 passes", per_req_o, 1);
        step(2);
        per_req_i = 0; per_gnt_i = 0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
